// File: rtl/bd_clkgen_pkg.sv
// Shared types and reset constants for the bd_clkgen multi-channel clock generator.
package bd_clkgen_pkg;

    localparam int CFG_DIV_W       = 8;
    localparam int CFG_PHASE_W     = 8;
    localparam int CFG_DEFAULT_DIV = 5;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef struct packed {
        logic [CFG_DIV_W-1:0]   div;
        logic [CFG_PHASE_W-1:0] phase;
    } chan_cfg_t;

endpackage

// File: rtl/bd_clkgen_chan.sv
// One output clock channel: half-period counter, start flag, registered clock and rise strobe.
// The rise strobe register exists only when BD_CLKGEN_STROBES_EN is defined.
module bd_clkgen_chan #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_clk,
    output logic             o_rise,
    output logic             o_started
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_started;

    // Counter, output clock and start flag; a start forces the clock high and arms a half period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= {DIV_W{1'b0}};
            r_clk     <= 1'b0;
            r_started <= 1'b0;
        end else if (i_clear) begin
            r_cnt     <= {DIV_W{1'b0}};
            r_clk     <= 1'b0;
            r_started <= 1'b0;
        end else if (i_start) begin
            r_cnt     <= i_div - DIV_W'(1);
            r_clk     <= 1'b1;
            r_started <= 1'b1;
        end else if (r_started && (r_cnt == {DIV_W{1'b0}})) begin
            r_cnt <= i_div - DIV_W'(1);
            r_clk <= ~r_clk;
        end else if (r_started) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

`ifdef BD_CLKGEN_STROBES_EN
    logic r_rise;

    // Strobe registered alongside r_clk so it is high exactly in the cycle r_clk first reads 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rise <= 1'b0;
        end else if (i_clear) begin
            r_rise <= 1'b0;
        end else begin
            r_rise <= i_start | (r_started && (r_cnt == {DIV_W{1'b0}}) && !r_clk);
        end
    end

    assign o_rise = r_rise;
`else
    assign o_rise = 1'b0;
`endif

    assign o_clk     = r_clk;
    assign o_started = r_started;

endmodule

// File: rtl/bd_clkgen.sv
// Programmable multi-channel clock generator with phase-aligned start and lock indication.
// Optional build macro BD_CLKGEN_STROBES_EN enables the outclk_rise strobes.
module bd_clkgen
    import bd_clkgen_pkg::*;
#(
    parameter int NUM_CLKS    = 2,
    parameter int DIV_W       = CFG_DIV_W,
    parameter int PHASE_W     = CFG_PHASE_W,
    parameter int DEFAULT_DIV = CFG_DEFAULT_DIV,
    parameter int LOCK_CYCLES = 16,
    localparam int SEL_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [PHASE_W-1:0]  cfg_phase,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] outclk_rise,
    output logic                locked
);

    localparam int SCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_e              r_state;
    state_e              w_fsm_nxt;
    state_e              w_state_nxt;
    logic [PHASE_W-1:0]  r_sc;
    logic [PHASE_W-1:0]  w_sc_fsm;
    logic [PHASE_W-1:0]  w_sc_nxt;
    logic [SCNT_W-1:0]   r_scnt;
    logic [SCNT_W-1:0]   w_scnt_nxt;
    logic                r_locked;
    logic                r_cfg_ready;
    chan_cfg_t           r_cfg [NUM_CLKS];
    logic [NUM_CLKS-1:0] w_start;
    logic [NUM_CLKS-1:0] w_started;
    logic [NUM_CLKS-1:0] w_done;
    logic [NUM_CLKS-1:0] w_outclk;
    logic [NUM_CLKS-1:0] w_rise;
    logic                w_accept;

    assign w_accept = cfg_valid && r_cfg_ready;

    for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
        logic [DIV_W-1:0]   w_div;
        logic [PHASE_W-1:0] w_phase;

        assign w_div   = DIV_W'(r_cfg[g].div);
        assign w_phase = PHASE_W'(r_cfg[g].phase);
        assign w_start[g] = (r_state == SYNC) && (w_div != {DIV_W{1'b0}})
                            && !w_started[g] && (w_phase == r_sc);
        // Disabled channels never start but must not hold the FSM in SYNC.
        assign w_done[g]  = w_started[g] | (w_div == {DIV_W{1'b0}}) | w_start[g];

        bd_clkgen_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .i_clk     (refclk),
            .i_rst_n   (rst_n),
            .i_start   (w_start[g]),
            .i_clear   (w_accept),
            .i_div     (w_div),
            .o_clk     (w_outclk[g]),
            .o_rise    (w_rise[g]),
            .o_started (w_started[g])
        );
    end

    // Next-state logic for the global SYNC/SETTLE/LOCKED sequencer.
    always_comb begin
        w_fsm_nxt  = r_state;
        w_sc_fsm   = r_sc;
        w_scnt_nxt = r_scnt;
        case (r_state)
            SYNC: begin
                if (r_sc != {PHASE_W{1'b1}}) begin
                    w_sc_fsm = r_sc + PHASE_W'(1);
                end else begin
                    w_sc_fsm = r_sc;
                end
                if (&w_done) begin
                    w_fsm_nxt  = SETTLE;
                    w_scnt_nxt = SCNT_W'(LOCK_CYCLES - 1);
                end else begin
                    w_fsm_nxt  = SYNC;
                end
            end
            SETTLE: begin
                if (r_scnt == {SCNT_W{1'b0}}) begin
                    w_fsm_nxt = LOCKED;
                end else begin
                    w_scnt_nxt = r_scnt - SCNT_W'(1);
                end
            end
            LOCKED: begin
                w_fsm_nxt = LOCKED;
            end
            default: begin
                w_fsm_nxt = SYNC;
                w_sc_fsm  = {PHASE_W{1'b0}};
            end
        endcase
    end

    assign w_state_nxt = w_accept ? SYNC : w_fsm_nxt;
    assign w_sc_nxt    = w_accept ? {PHASE_W{1'b0}} : w_sc_fsm;

    // Sequencer state plus registered lock and ready flags derived from the next state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SYNC;
            r_sc        <= {PHASE_W{1'b0}};
            r_scnt      <= {SCNT_W{1'b0}};
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc        <= w_sc_nxt;
            r_scnt      <= w_scnt_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_cfg_ready <= (w_state_nxt != SYNC);
        end
    end

    // Per-channel configuration; selectors beyond NUM_CLKS match no entry and are dropped.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                r_cfg[i].div   <= CFG_DIV_W'(DEFAULT_DIV);
                r_cfg[i].phase <= {CFG_PHASE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                if (w_accept && (int'(cfg_sel) == i)) begin
                    r_cfg[i].div   <= CFG_DIV_W'(cfg_div);
                    r_cfg[i].phase <= CFG_PHASE_W'(cfg_phase);
                end
            end
        end
    end

    assign outclk      = w_outclk;
    assign outclk_rise = w_rise;
    assign locked      = r_locked;
    assign cfg_ready   = r_cfg_ready;

endmodule

// File: tb/tb_bd_clkgen.sv
// Randomized self-checking bench for bd_clkgen against a cycle-index reference model.
module tb_bd_clkgen;

    localparam int N  = 2;
    localparam int LC = 16;

    logic         refclk    = 1'b0;
    logic         rst_n     = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [0:0]   cfg_sel   = 1'b0;
    logic [7:0]   cfg_div   = 8'd0;
    logic [7:0]   cfg_phase = 8'd0;
    logic [N-1:0] outclk;
    logic [N-1:0] outclk_rise;
    logic         locked;

    int n_checks = 0;
    int n_errors = 0;
    int t;
    int m_div   [N];
    int m_phase [N];
    bit acc;

    always #5 refclk = ~refclk;

    bd_clkgen #(
        .NUM_CLKS    (N),
        .DIV_W       (8),
        .PHASE_W     (8),
        .DEFAULT_DIV (5),
        .LOCK_CYCLES (LC)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_sel     (cfg_sel),
        .cfg_div     (cfg_div),
        .cfg_phase   (cfg_phase),
        .outclk      (outclk),
        .outclk_rise (outclk_rise),
        .locked      (locked)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    function automatic int max_phase();
        int p = 0;
        for (int i = 0; i < N; i++)
            if (m_div[i] != 0 && m_phase[i] > p) p = m_phase[i];
        return p;
    endfunction

    // Channel i is high for div cycles starting at phase+1, then low for div, repeating.
    function automatic logic [N-1:0] exp_clk();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (m_div[i] != 0 && t >= m_phase[i] + 1)
                v[i] = (((t - m_phase[i] - 1) / m_div[i]) % 2) == 0;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_rise();
        logic [N-1:0] v = '0;
`ifdef BD_CLKGEN_STROBES_EN
        for (int i = 0; i < N; i++)
            if (m_div[i] != 0 && t >= m_phase[i] + 1)
                v[i] = ((t - m_phase[i] - 1) % (2 * m_div[i])) == 0;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_div[i]   = 5;
            m_phase[i] = 0;
        end
        t = 0;
    endtask

    task automatic cycle();
        check_val("outclk", 32'(outclk), 32'(exp_clk()));
        check_val("outclk_rise", 32'(outclk_rise), 32'(exp_rise()));
        check_val("locked", 32'(locked), 32'(t >= max_phase() + 1 + LC));
        check_val("cfg_ready", 32'(cfg_ready), 32'(t >= max_phase() + 1));
        acc = cfg_valid && (t >= max_phase() + 1);
        @(posedge refclk);
        if (acc) begin
            m_div[int'(cfg_sel)]   = int'(cfg_div);
            m_phase[int'(cfg_sel)] = int'(cfg_phase);
            t = 0;
        end else begin
            t++;
        end
        @(negedge refclk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic write(input int sel, input int div, input int ph);
        int waited = 0;
        cfg_sel   = sel[0:0];
        cfg_div   = div[7:0];
        cfg_phase = ph[7:0];
        cfg_valid = 1'b1;
        do begin
            cycle();
            waited++;
        end while (!acc && waited < 700);
        check_val("write_accept", 32'(acc), 32'd1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge refclk);
        check_val("rst_outclk", 32'(outclk), 32'd0);
        check_val("rst_rise", 32'(outclk_rise), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;
        t = 0;

        run(40);
        write(1, 5, 3);
        run(40);

        write(0, 1, 0);
        run(20);
        write(1, 0, 0);
        run(30);

        // Second write is presented while the first resync is still in SYNC.
        write(1, 4, 2);
        write(0, 3, 7);
        run(40);

        write(0, 2, 255);
        run(300);

        @(posedge refclk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_outclk", 32'(outclk), 32'd0);
        check_val("arst_rise", 32'(outclk_rise), 32'd0);
        check_val("arst_locked", 32'(locked), 32'd0);
        check_val("arst_ready", 32'(cfg_ready), 32'd0);
        @(negedge refclk);
        rst_n = 1'b1;
        model_reset();
        run(40);

        write(0, 0, 0);
        write(1, 0, 4);
        run(25);

        repeat (25) begin
            write(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 12)));
            run(int'($urandom_range(0, 40)));
        end
        run(60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
